// File: rtl/cpu_rf_pkg.sv
// Shared constants for the CPU register file: default geometry and the hardwired-zero index.
package cpu_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_IDX   = 0;

  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: read ports, writeback and issue strobes.
interface regfile_sb_if
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_sb_busy.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, looked up per read port.
module regfile_sb_busy
  import cpu_rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int NREGS = nregs(ADDR_W);

  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [ADDR_W-1:0] ra_s;
  logic              fwd_s;

  // Issue beats writeback on the same register: the younger producer is still outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if ((ZERO_REG != 0) && (r == ZERO_IDX)) begin
        busy_d[r] = 1'b0;
      end else if (iss_en && (iss_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // Busy vector state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A same-cycle writeback hides busy only when no same-cycle issue re-arms it.
  always_comb begin
    rd_busy = '0;
    ra_s    = '0;
    fwd_s   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra_s  = rd_addr[i*ADDR_W +: ADDR_W];
      fwd_s = (BYPASS != 0) && wr_en && (wr_addr == ra_s) && !(iss_en && (iss_addr == ra_s));
      if (!rst_n) begin
        rd_busy[i] = 1'b0;
      end else if (fwd_s) begin
        rd_busy[i] = 1'b0;
      end else begin
        rd_busy[i] = busy_q[ra_s];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Flop-based register file with combinational read ports, write bypass, zero register and busy scoreboard.
module regfile_sb
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);
  localparam int NREGS = nregs(ADDR_W);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_hit_s;
  logic [ADDR_W-1:0] ra_s;

  assign wr_hit_s = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(ZERO_IDX)));

  // Next-state of the register array.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < NREGS; r++) begin
      if (wr_hit_s && (bus.wr_addr == ADDR_W'(r))) begin
        regs_d[r] = bus.wr_data;
      end else begin
        regs_d[r] = regs_q[r];
      end
    end
  end

  // Register array with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes; outputs forced to zero while reset is held.
  always_comb begin
    bus.rd_data = '0;
    ra_s        = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra_s = bus.rd_addr[i*ADDR_W +: ADDR_W];
      if (!rst_n) begin
        bus.rd_data[i*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (ra_s == ADDR_W'(ZERO_IDX))) begin
        bus.rd_data[i*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == ra_s)) begin
        bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
      end else begin
        bus.rd_data[i*DATA_W +: DATA_W] = regs_q[ra_s];
      end
    end
  end

  regfile_sb_busy #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_busy (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default build via vector table + scoreboard queue, plus a narrow 4-port build.
module tb_regfile_sb;
  import cpu_rf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ia ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) ib ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  isa;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
  } exp_t;

  vec_t tbl [16];
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ie, input logic [4:0] isa,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.isa = isa;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, tag, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    exp_t e;
    ia.wr_en    = v.we;
    ia.wr_addr  = v.wa;
    ia.wr_data  = v.wd;
    ia.iss_en   = v.ie;
    ia.iss_addr = v.isa;
    ia.rd_addr  = {v.r1, v.r0};
    e.d0 = v.d0; e.d1 = v.d1; e.b0 = v.b0; e.b1 = v.b1;
    sb_q.push_back(e);
  endtask

  task automatic check_a(input int tag);
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty[%0d] got=0 want=1", tag);
    end else begin
      e = sb_q.pop_front();
      chk("a_rd_data0", tag, ia.rd_data[31:0], e.d0);
      chk("a_rd_data1", tag, ia.rd_data[63:32], e.d1);
      chk("a_rd_busy0", tag, 32'(ia.rd_busy[0]), 32'(e.b0));
      chk("a_rd_busy1", tag, 32'(ia.rd_busy[1]), 32'(e.b1));
    end
  endtask

  logic [15:0] model_b [8];
  logic [15:0] wval;
  logic [11:0] rab;

  initial begin
    tbl[0]  = mk(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd0, 32'h12345678, 32'h0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd3, 32'h12345678, 32'h0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h12345678, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd3, 32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1);
    tbl[7]  = mk(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 5'd9, 5'd3, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 5'd4, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 5'd4, 32'h11,       1'b1, 5'd4, 5'd4, 5'd4, 32'h11, 32'h11, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4, 32'h11, 32'h11, 1'b1, 1'b1);
    tbl[14] = mk(1'b1, 5'd6, 32'h77,       1'b0, 5'd0, 5'd6, 5'd6, 32'h77, 32'h77, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd6, 5'd4, 32'h77, 32'h11, 1'b0, 1'b1);

    ib.wr_en = 1'b0; ib.wr_addr = '0; ib.wr_data = '0;
    ib.iss_en = 1'b0; ib.iss_addr = '0; ib.rd_addr = '0;
    for (int r = 0; r < 8; r++) model_b[r] = 16'h0;

    // Reset held: outputs zero even with a bypassing write presented.
    rst_n = 1'b0;
    drive_a(mk(1'b1, 5'd3, 32'hFF, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0));
    check_a(100);
    @(negedge clk);
    drive_a(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0));
    rst_n = 1'b1;
    check_a(101);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_a(tbl[i]);
      check_a(i);
    end

    // Mid-stream async reset clears r5 and the r4 busy bit immediately.
    @(negedge clk);
    drive_a(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd4, 32'hDEADBEEF, 32'h11, 1'b0, 1'b1));
    check_a(200);
    @(negedge clk);
    drive_a(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd4, 32'hDEADBEEF, 32'h11, 1'b0, 1'b1));
    check_a(201);
    #2;
    rst_n = 1'b0;
    drive_a(mk(1'b1, 5'd5, 32'h1, 1'b1, 5'd4, 5'd5, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0));
    check_a(202);
    @(negedge clk);
    drive_a(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0));
    check_a(203);
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(mk(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 5'd5, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0));
    check_a(204);
    @(negedge clk);
    drive_a(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd4, 32'h22, 32'h0, 1'b0, 1'b1));
    check_a(205);
    @(negedge clk);
    drive_a(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0));
    check_a(206);

    // Narrow build, no zero register, no bypass: same-cycle read sees the old value.
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      wval = 16'h1000 + 16'(r) * 16'h0111;
      ib.wr_en = 1'b1; ib.wr_addr = 3'(r); ib.wr_data = wval;
      ib.rd_addr = {4{3'(r)}};
      #1;
      chk("b_nobypass", r, 32'(ib.rd_data[15:0]), 32'(model_b[r]));
      model_b[r] = wval;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ib.wr_en = 1'b0;
      rab = '0;
      for (int p = 0; p < 4; p++) rab[p*3 +: 3] = 3'((k + p) % 8);
      ib.rd_addr = rab;
      #1;
      for (int p = 0; p < 4; p++) begin
        chk("b_rd_data", k*4 + p, 32'(ib.rd_data[p*16 +: 16]), 32'(model_b[(k + p) % 8]));
        chk("b_rd_busy", k*4 + p, 32'(ib.rd_busy[p]), 32'h0);
      end
    end
    @(negedge clk);
    ib.iss_en = 1'b1; ib.iss_addr = 3'd0; ib.rd_addr = '0;
    #1;
    chk("b_iss_r0_same", 0, 32'(ib.rd_busy), 32'h0);
    @(negedge clk);
    ib.iss_en = 1'b0; ib.wr_en = 1'b1; ib.wr_addr = 3'd0; ib.wr_data = 16'hBEEF;
    #1;
    chk("b_r0_busy_wr", 0, 32'(ib.rd_busy), 32'hF);
    chk("b_r0_old", 0, 32'(ib.rd_data[15:0]), 32'(model_b[0]));
    @(negedge clk);
    ib.wr_en = 1'b0;
    #1;
    chk("b_r0_cleared", 0, 32'(ib.rd_busy), 32'h0);
    chk("b_r0_new", 0, 32'(ib.rd_data[63:48]), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
